filt_mac_ctrl: RTL and testbench
================================

# filt_mac_ctrl

Sequencer for the time-multiplexed, single-multiplier FIR filter path. It accepts input samples over a valid/ready handshake and stores them in a circular delay line. For each sample it issues the tap-pair/coefficient-index schedule and the accumulator controls to the external pre-add/MAC datapath, then pulses `o_done` once the datapath result has settled. It sits between the sample source and the MAC datapath and owns all filter timing.

## Interface
Parameters:
- `gp_inp_width`, 8: sample width (signed).
- `gp_coeff_length`, 17: number of taps N, at least 2.
- `gp_symm`, 1: 1 means symmetric coefficients (pair folding), 0 means direct form.
- `gp_mac_latency`, 2: datapath cycles from the last `o_mac_en` to result valid, at least 1.
- `gp_cidx_width`, `$clog2(gp_coeff_length)`: coefficient index width.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_ena` in 1: global enable; low freezes the sequencer.
- `i_valid` in 1: input sample valid.
- `i_data` in `gp_inp_width`: signed input sample.
- `o_ready` out 1: sample accepted when `i_valid & o_ready`.
- `o_tap_a` out `gp_inp_width`: pre-adder operand A.
- `o_tap_b` out `gp_inp_width`: pre-adder operand B.
- `o_coeff_idx` out `gp_cidx_width`: coefficient ROM address.
- `o_mac_en` out 1: datapath accumulate strobe.
- `o_mac_clr` out 1: load the accumulator instead of adding (first product of a sample).
- `o_mac_last` out 1: last product of this sample.
- `o_done` out 1: one-cycle pulse, datapath output valid.
- `o_busy` out 1: high when not in IDLE.

## Operation
- K = `gp_symm` ? ceil(N/2) : N. With the defaults, K = 9.
- Delay line: N entries of `gp_inp_width` bits with write pointer `wp`. Define x[j] = mem[(wp − j) mod N], so x[0] is the newest sample.
- On accept, `wp` advances by 1 mod N (N−1 wraps to 0), then the sample is written. The oldest entry is overwritten.
- States:
  - IDLE: `o_ready = i_ena`. On accept, go to RUN with k = 0.
  - RUN: drive one product per enabled cycle for k = 0..K−1. After k = K−1, go to DRAIN with cnt = `gp_mac_latency`−1.
  - DRAIN: if cnt = 0, go to IDLE with `o_done` = 1. Otherwise decrement cnt.
- RUN outputs, all registered and valid in the same cycle as `o_mac_en`:
  - `o_coeff_idx` = k and `o_tap_a` = x[k].
  - Symmetric mode: `o_tap_b` = x[N−1−k]. If N is odd and k = (N−1)/2, `o_tap_b` = 0 so the centre tap is not doubled.
  - Direct mode: `o_tap_b` = 0.
  - `o_mac_clr` = (k == 0) and `o_mac_last` = (k == K−1).
- Outside RUN: `o_mac_en`, `o_mac_clr` and `o_mac_last` are 0. Taps and index hold their last values.
- `i_ena` low: state, k, cnt and `wp` all hold; `o_mac_en` = 0; `o_ready` = 0; no accept. On re-enable, the schedule resumes at the same k with no skipped or repeated index.
- `i_data` is ignored unless accepted. `i_valid` asserted outside IDLE is back-pressured, never dropped.
- Reset mid-operation: the sequence is aborted, no `o_done` is issued, and the delay line is cleared.

## Timing
- Reset values: state IDLE; `wp` = 0; delay line all zeros; k and cnt = 0; `o_tap_a`, `o_tap_b`, `o_coeff_idx`, `o_mac_*`, `o_done` and `o_busy` all 0. `o_ready` is 1 in the first cycle after reset if `i_ena` is 1.
- Sample accepted at edge t:
  - `o_mac_en` and `o_mac_clr` are high in cycle t+1.
  - `o_mac_last` is high in cycle t+K.
  - `o_done` is high in cycle t+K+`gp_mac_latency`.
- The cycle carrying `o_done` is already IDLE, so `o_ready` is 1 in that cycle. Back-to-back period is K + `gp_mac_latency` cycles (11 with the defaults), assuming `i_ena` stays high.
- `o_done` is asserted for exactly 1 cycle per accepted sample. `o_done` must not assert unless the sample completed the full K products.

## Structure
- Package `filt_mac_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a function `f_div2(n)` returning (n/2)+(n%2);
  - a function `f_num_macs(n, symm)` returning K.
- Sub-module `filt_mac_dline`: circular delay line with write port, pointer wrap, and two combinational read ports x[ja], x[jb].
- The controller FSM, counters and output registers live in `filt_mac_ctrl`.

## Test plan
- Reset: assert `i_rst` for 3 cycles with `i_ena` = 1. After release, `o_ready` = 1 and every other output = 0. Delay line reads all 0.
- Impulse: accept 128 at t.
  - Cycles t+1..t+9 show `o_coeff_idx` 0..8, `o_tap_a` = 128 at k = 0 and 0 after, `o_tap_b` = 0 throughout.
  - `o_mac_clr` only at t+1, `o_mac_last` only at t+9, `o_done` only at t+11.
- Symmetric pairing: feed 1..17 back-to-back.
  - On the 17th sample, k = 0 gives a = 17, b = 1.
  - k = 7 gives a = 10, b = 8.
  - k = 8 gives a = 9, b = 0 (centre tap).
  - Feeding an 18th sample gives k = 0 a = 18, b = 2 (wrap check).
- Back-pressure: hold `i_valid` = 1 continuously with a new value per accept. Accepts occur exactly every 11 cycles, with no sample lost or duplicated.
- Enable stall: drop `i_ena` for 4 cycles at k = 4. `o_mac_en` = 0 and the index holds at 4. Resume at k = 4; `o_done` is delayed by exactly 4 cycles.
- Reset mid-RUN at k = 5: no `o_done` is issued. The next impulse produces the fresh-reset response from the impulse scenario.
- Direct mode (`gp_symm` = 0): K = 17 and `o_tap_b` is always 0. `o_done` arrives at t+19.

Source files
------------

// File: rtl/filt_mac_pkg.sv
// Shared types and elaboration-time helpers for the FIR MAC sequencer.
package filt_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Ceiling of n/2.
    function automatic int f_div2(input int n);
        return (n / 2) + (n % 2);
    endfunction

    // Products issued per sample: folded pairs when symmetric, every tap otherwise.
    function automatic int f_num_macs(input int n, input int symm);
        return (symm != 0) ? f_div2(n) : n;
    endfunction

endpackage

// File: rtl/filt_mac_dline.sv
// Circular sample delay line: one write port, two combinational read ports
// addressed by age j (x[j] = mem[(wp - j) mod depth], x[0] newest).
module filt_mac_dline #(
    parameter int gp_inp_width = 8,
    parameter int gp_depth     = 17,
    parameter int gp_aw        = $clog2(gp_depth)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr,
    input  logic [gp_inp_width-1:0] i_data,
    input  logic [gp_aw-1:0]        i_ja,
    input  logic [gp_aw-1:0]        i_jb,
    output logic [gp_inp_width-1:0] o_xa,
    output logic [gp_inp_width-1:0] o_xb
);
    import filt_mac_pkg::*;

    localparam logic [gp_aw:0]   DEPTH_W = (gp_aw + 1)'(gp_depth);
    localparam logic [gp_aw-1:0] LAST_W  = gp_aw'(gp_depth - 1);

    logic [gp_inp_width-1:0] mem [gp_depth];
    logic [gp_aw-1:0]        wp;
    logic [gp_aw-1:0]        wp_next;

    // Map an age j to a physical slot; wp + depth - j never exceeds 2*depth-1.
    function automatic logic [gp_aw-1:0] f_addr(input logic [gp_aw-1:0] p,
                                                 input logic [gp_aw-1:0] j);
        logic [gp_aw:0] s;
        s = {1'b0, p} + DEPTH_W - {1'b0, j};
        if (s >= DEPTH_W) s = s - DEPTH_W;
        return s[gp_aw-1:0];
    endfunction

    // Pointer advance with wrap at depth-1.
    always_comb begin
        wp_next = (wp == LAST_W) ? '0 : wp + 1'b1;
    end

    // Advance the pointer, then overwrite the oldest slot with the new sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp <= '0;
            for (int unsigned i = 0; i < gp_depth; i++) mem[i] <= '0;
        end else if (i_wr) begin
            wp           <= wp_next;
            mem[wp_next] <= i_data;
        end
    end

    // Age-addressed read ports.
    always_comb begin
        o_xa = mem[f_addr(wp, i_ja)];
        o_xb = mem[f_addr(wp, i_jb)];
    end

endmodule

// File: rtl/filt_mac_ctrl.sv
// Sequencer for the single-multiplier FIR path: accepts samples, issues the
// tap-pair / coefficient schedule and accumulator strobes, pulses o_done.
module filt_mac_ctrl #(
    parameter int gp_inp_width    = 8,
    parameter int gp_coeff_length = 17,
    parameter int gp_symm         = 1,
    parameter int gp_mac_latency  = 2,
    parameter int gp_cidx_width   = $clog2(gp_coeff_length)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ena,
    input  logic                     i_valid,
    input  logic [gp_inp_width-1:0]  i_data,
    output logic                     o_ready,
    output logic [gp_inp_width-1:0]  o_tap_a,
    output logic [gp_inp_width-1:0]  o_tap_b,
    output logic [gp_cidx_width-1:0] o_coeff_idx,
    output logic                     o_mac_en,
    output logic                     o_mac_clr,
    output logic                     o_mac_last,
    output logic                     o_done,
    output logic                     o_busy
);
    import filt_mac_pkg::*;

    localparam int N   = gp_coeff_length;
    localparam int K   = f_num_macs(N, gp_symm);
    localparam int AW  = $clog2(N);
    localparam int KW  = $clog2(N + 1);
    localparam int CW  = $clog2(gp_mac_latency + 1);
    localparam bit ODD = (N % 2) != 0;

    localparam logic [KW-1:0] K_W      = KW'(K);
    localparam logic [KW-1:0] KLAST_W  = KW'(K - 1);
    localparam logic [KW-1:0] CENTRE_W = KW'((N - 1) / 2);

    state_t                  state;
    logic [KW-1:0]           k;        // index of the next product to issue
    logic [CW-1:0]           cnt;
    logic                    mac_en_q, mac_clr_q, mac_last_q, done_q;
    logic                    accept;
    logic                    is_centre;
    logic [AW-1:0]           ja_c, jb_c;
    logic [gp_inp_width-1:0] xa, xb;

    filt_mac_dline #(
        .gp_inp_width (gp_inp_width),
        .gp_depth     (N),
        .gp_aw        (AW)
    ) u_dline (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_wr   (accept),
        .i_data (i_data),
        .i_ja   (ja_c),
        .i_jb   (jb_c),
        .o_xa   (xa),
        .o_xb   (xb)
    );

    // Handshake and read addressing. The k=0 product is registered on the
    // accept edge itself, before the new sample lands, so its partner tap
    // x[N-1] is fetched as the pre-write x[N-2].
    always_comb begin
        o_ready   = (state == ST_IDLE) && i_ena;
        accept    = o_ready && i_valid;
        is_centre = (gp_symm != 0) && ODD && (k == CENTRE_W);
        ja_c      = '0;
        jb_c      = '0;
        if (state == ST_IDLE) begin
            jb_c = AW'(N - 2);
        end else if (k < K_W) begin
            ja_c = AW'(k);
            jb_c = AW'(N - 1) - AW'(k);
        end
    end

    // Strobes are held while disabled and masked by i_ena, so a product that
    // was on the bus when the stall began is re-presented on resume.
    always_comb begin
        o_mac_en   = mac_en_q   && i_ena;
        o_mac_clr  = mac_clr_q  && i_ena;
        o_mac_last = mac_last_q && i_ena;
        o_done     = done_q     && i_ena;
        o_busy     = (state != ST_IDLE);
    end

    // Controller FSM with registered schedule outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            cnt         <= '0;
            o_tap_a     <= '0;
            o_tap_b     <= '0;
            o_coeff_idx <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else if (i_ena) begin
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        o_tap_a     <= i_data;
                        o_tap_b     <= (gp_symm != 0) ? xb : '0;
                        o_coeff_idx <= '0;
                        mac_en_q    <= 1'b1;
                        mac_clr_q   <= 1'b1;
                        mac_last_q  <= (K == 1);
                        k           <= KW'(1);
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (k < K_W) begin
                        o_tap_a     <= xa;
                        o_tap_b     <= ((gp_symm != 0) && !is_centre) ? xb : '0;
                        o_coeff_idx <= gp_cidx_width'(k);
                        mac_en_q    <= 1'b1;
                        mac_last_q  <= (k == KLAST_W);
                        k           <= k + 1'b1;
                    end else begin
                        k <= '0;
                        if (gp_mac_latency == 1) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                            cnt   <= CW'(gp_mac_latency - 2);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filt_mac_ctrl.sv
// Directed bench for filt_mac_ctrl: symmetric (default) and direct-form instances.
module tb_filt_mac_ctrl;

    logic       clk = 1'b0;
    logic       rst, ena, valid, sel;
    logic [7:0] data;
    logic       v_s, v_d;

    logic       rdy_s, en_s, clr_s, last_s, done_s, busy_s;
    logic       rdy_d, en_d, clr_d, last_d, done_d, busy_d;
    logic [7:0] a_s, b_s, a_d, b_d;
    logic [4:0] idx_s, idx_d;

    logic       o_rdy, o_en, o_clr, o_last, o_done, o_busy;
    logic [7:0] o_a, o_b;
    logic [4:0] o_idx;

    int n_checks = 0;
    int n_errors = 0;

    int rec_en [0:31];
    int rec_clr[0:31];
    int rec_lst[0:31];
    int rec_dn [0:31];
    int rec_idx[0:31];
    int rec_a  [0:31];
    int rec_b  [0:31];

    always #5 clk = ~clk;

    assign v_s = valid & ~sel;
    assign v_d = valid &  sel;

    assign o_rdy  = sel ? rdy_d  : rdy_s;
    assign o_en   = sel ? en_d   : en_s;
    assign o_clr  = sel ? clr_d  : clr_s;
    assign o_last = sel ? last_d : last_s;
    assign o_done = sel ? done_d : done_s;
    assign o_busy = sel ? busy_d : busy_s;
    assign o_a    = sel ? a_d    : a_s;
    assign o_b    = sel ? b_d    : b_s;
    assign o_idx  = sel ? idx_d  : idx_s;

    filt_mac_ctrl #(
        .gp_inp_width (8), .gp_coeff_length (17), .gp_symm (1), .gp_mac_latency (2)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_ena (ena), .i_valid (v_s), .i_data (data),
        .o_ready (rdy_s), .o_tap_a (a_s), .o_tap_b (b_s), .o_coeff_idx (idx_s),
        .o_mac_en (en_s), .o_mac_clr (clr_s), .o_mac_last (last_s),
        .o_done (done_s), .o_busy (busy_s)
    );

    filt_mac_ctrl #(
        .gp_inp_width (8), .gp_coeff_length (17), .gp_symm (0), .gp_mac_latency (2)
    ) dut_d (
        .i_clk (clk), .i_rst (rst), .i_ena (ena), .i_valid (v_d), .i_data (data),
        .o_ready (rdy_d), .o_tap_a (a_d), .o_tap_b (b_d), .o_coeff_idx (idx_d),
        .o_mac_en (en_d), .o_mac_clr (clr_d), .o_mac_last (last_d),
        .o_done (done_d), .o_busy (busy_d)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: wait for ready, accept v, record cycles t+1..t+w.
    task automatic run_sample(input int v, input int w);
        int n;
        n = 0;
        while (!o_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(o_rdy), 1);
        valid = 1'b1;
        data  = v[7:0];
        @(negedge clk);
        valid = 1'b0;
        for (int j = 1; j <= w; j++) begin
            rec_en[j]  = int'(o_en);
            rec_clr[j] = int'(o_clr);
            rec_lst[j] = int'(o_last);
            rec_dn[j]  = int'(o_done);
            rec_idx[j] = int'(o_idx);
            rec_a[j]   = int'(o_a);
            rec_b[j]   = int'(o_b);
            if (j < w) @(negedge clk);
        end
    endtask

    task automatic check_impulse(input string tag);
        for (int j = 1; j <= 11; j++) begin
            chk({tag, "_en"},   rec_en[j],  (j <= 9) ? 1 : 0);
            chk({tag, "_clr"},  rec_clr[j], (j == 1) ? 1 : 0);
            chk({tag, "_last"}, rec_lst[j], (j == 9) ? 1 : 0);
            chk({tag, "_done"}, rec_dn[j],  (j == 11) ? 1 : 0);
            if (j <= 9) begin
                chk({tag, "_idx"}, rec_idx[j], j - 1);
                chk({tag, "_a"},   rec_a[j],   (j == 1) ? 128 : 0);
                chk({tag, "_b"},   rec_b[j],   0);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(o_busy), 0);
    endtask

    initial begin
        int acc_j[4];
        int nacc, nclr, j, done_j, ndone, stalled, n;

        rst = 1'b1; ena = 1'b1; valid = 1'b0; sel = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", int'(o_rdy),  1);
        chk("rst_en",    int'(o_en),   0);
        chk("rst_clr",   int'(o_clr),  0);
        chk("rst_last",  int'(o_last), 0);
        chk("rst_done",  int'(o_done), 0);
        chk("rst_busy",  int'(o_busy), 0);
        chk("rst_a",     int'(o_a),    0);
        chk("rst_b",     int'(o_b),    0);
        chk("rst_idx",   int'(o_idx),  0);
        @(negedge clk);

        // Impulse on a freshly cleared delay line.
        run_sample(128, 11);
        check_impulse("imp");
        chk("imp_ready_at_done", int'(o_rdy), 1);
        chk("imp_busy_at_done",  int'(o_busy), 0);

        // Symmetric pairing with ramp 1..17, then wrap with 18.
        for (int i = 1; i <= 17; i++) begin
            run_sample(i, 11);
            chk("ramp_done", rec_dn[11], 1);
        end
        chk("pair_k0_a", rec_a[1], 17);
        chk("pair_k0_b", rec_b[1], 1);
        chk("pair_k7_a", rec_a[8], 10);
        chk("pair_k7_b", rec_b[8], 8);
        chk("pair_k8_a", rec_a[9], 9);
        chk("pair_k8_b", rec_b[9], 0);
        run_sample(18, 11);
        chk("wrap_k0_a", rec_a[1], 18);
        chk("wrap_k0_b", rec_b[1], 2);

        // Back-pressure: valid held high, new value after each accept.
        nacc = 0; nclr = 0; j = 0;
        for (int i = 0; i < 4; i++) acc_j[i] = 0;
        valid = 1'b1; data = 8'd50;
        while (nclr < 4 && j < 80) begin
            if (o_clr) begin
                chk("bp_value", int'(o_a), 50 + nclr);
                nclr++;
                data = 8'(50 + nclr);
                if (nclr == 4) valid = 1'b0;
            end
            if (o_rdy && valid && nacc < 4) begin
                acc_j[nacc] = j;
                nacc++;
            end
            @(negedge clk);
            j++;
        end
        valid = 1'b0;
        chk("bp_count", nclr, 4);
        for (int i = 1; i < 4; i++) chk("bp_period", acc_j[i] - acc_j[i-1], 11);
        wait_idle("bp_idle");

        // Enable stall at k = 4.
        valid = 1'b1; data = 8'd100;
        chk("stall_ready", int'(o_rdy), 1);
        @(negedge clk);
        valid = 1'b0;
        j = 1; done_j = -1; ndone = 0; stalled = 0;
        while (j <= 30) begin
            if (o_done) begin
                ndone++;
                if (done_j < 0) done_j = j;
            end
            if (j == 10) chk("resume_next_idx", int'(o_idx), 5);
            if (!stalled && o_en && o_idx == 5'd4) begin
                stalled = 1;
                ena = 1'b0;
                #1;
                chk("stall_en",  int'(o_en),  0);
                chk("stall_idx", int'(o_idx), 4);
                repeat (3) begin
                    @(negedge clk);
                    j++;
                    chk("stall_en",  int'(o_en),  0);
                    chk("stall_idx", int'(o_idx), 4);
                end
                @(negedge clk);
                j++;
                ena = 1'b1;
                #1;
                chk("resume_en",  int'(o_en),  1);
                chk("resume_idx", int'(o_idx), 4);
            end
            @(negedge clk);
            j++;
        end
        chk("stall_seen",     stalled, 1);
        chk("stall_done_cyc", done_j, 15);
        chk("stall_done_cnt", ndone, 1);

        // Reset in the middle of RUN at k = 5.
        valid = 1'b1; data = 8'd77;
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (!(o_en && o_idx == 5'd5) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_k5", int'(o_idx), 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_busy", int'(o_busy), 0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        chk("mid_no_done", ndone, 0);
        run_sample(128, 11);
        check_impulse("rimp");

        // Direct form: K = 17, tap_b always 0, done at t+19.
        sel = 1'b1;
        @(negedge clk);
        run_sample(5, 19);
        run_sample(6, 19);
        run_sample(7, 19);
        for (int jj = 1; jj <= 19; jj++) begin
            chk("dir_done", rec_dn[jj], (jj == 19) ? 1 : 0);
            chk("dir_last", rec_lst[jj], (jj == 17) ? 1 : 0);
            chk("dir_b",    rec_b[jj], 0);
            if (jj <= 17) begin
                chk("dir_en",  rec_en[jj], 1);
                chk("dir_idx", rec_idx[jj], jj - 1);
                chk("dir_a",   rec_a[jj], (jj == 1) ? 7 : (jj == 2) ? 6 : (jj == 3) ? 5 : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
